omsp_spm_cmd_seq: RTL and testbench
===================================

// Module: omsp_spm_cmd_seq
// PURPOSE
// Upstream sequencer for omsp_spm_control. Accepts one decoded Sancus protection
// command at a time, drives the one-cycle update/enable/disable/cancel/verify
// strobes into omsp_spm_control, samples its violation flag and returns a 16-bit
// result. It rolls back a failed PROTECT with a cancel strobe.
// PARAMETERS
// VERIFY_WAIT  1  cycles (>=1) between the verify_spm strobe and sampling violation
// PORTS
// mclk          in   1   core clock
// puc_rst       in   1   synchronous active-high reset
// cmd_valid     in   1   command request; held until accepted
// cmd_ready     out  1   sequencer can accept a command this cycle
// cmd_op        in   3   1=PROTECT 2=UNPROTECT 3=VERIFY 4=GET_ID 5=GET_PREV_ID; others illegal
// handling_irq  in   1   IRQ entry in progress; blocks acceptance
// violation     in   1   omsp_spm_control violation output
// spm_current_id in  16  omsp_spm_control current SM id
// spm_prev_id   in   16  omsp_spm_control previous SM id
// update_spm    out  1   strobe to omsp_spm_control
// enable_spm    out  1   strobe to omsp_spm_control
// disable_spm   out  1   strobe to omsp_spm_control
// cancel_spm    out  1   strobe to omsp_spm_control
// verify_spm    out  1   strobe to omsp_spm_control
// cmd_done      out  1   one-cycle completion pulse
// cmd_fail      out  1   valid with cmd_done; 1 = command failed
// cmd_result    out  16  valid with cmd_done; held until next cmd_done
// BEHAVIOUR
// - Reset (sampled on mclk): state IDLE, all strobes 0, cmd_done=0, cmd_fail=0,
//   cmd_result=0, id_shadow=16'h0001, wait counter=0. Reset mid-command drops it; no strobes issue.
// - cmd_ready = (state==IDLE) & ~handling_irq. Accept on cmd_valid & cmd_ready; latch op.
//   handling_irq after acceptance does not abort the command.
// - FSM: IDLE -> ISSUE -> {CHECK | VWAIT | DONE}; CHECK -> {DONE | CANCEL}; CANCEL -> DONE; DONE -> IDLE.
// - ISSUE is the cycle after acceptance; strobes are registered and high for exactly that one cycle:
//   PROTECT: update_spm=1, enable_spm=1. Go to CHECK.
//   UNPROTECT: if spm_current_id==0, no strobe, go to DONE with fail=1. Else update_spm=1 and
//     disable_spm=1, go to DONE with fail=0 and result=16'h0001.
//   VERIFY: verify_spm=1, load counter=VERIFY_WAIT-1, go to VWAIT.
//   GET_ID / GET_PREV_ID: no strobe. result=spm_current_id / spm_prev_id sampled in ISSUE; fail=0.
//   Illegal op: no strobe, fail=1, result=0.
// - VWAIT: decrement counter; when it reads 0, sample violation, then go to DONE.
//   fail=violation, result=spm_current_id.
// - CHECK (PROTECT, cycle after strobe): sample violation.
//   0: result=id_shadow, id_shadow+=1, go to DONE (fail=0).
//   1: go to CANCEL.
// - CANCEL: update_spm=1, cancel_spm=1, enable_spm=0 for one cycle; id_shadow unchanged;
//   then DONE with fail=1, result=0.
// - id_shadow mirrors next_id in omsp_spm_control. It wraps mod 2^16 and is never decremented,
//   because the control decrement on cancel pairs with its increment on enable.
// - DONE: cmd_done=1 for one cycle; cmd_fail/cmd_result update in that cycle. Next state IDLE.
//   cmd_ready is low in DONE. Back-to-back commands are therefore >=1 idle cycle apart.
// - Latency, acceptance to cmd_done: GET/illegal/UNPROTECT 2; PROTECT ok 3, fail 4;
//   VERIFY 2+VERIFY_WAIT.
// - At most one strobe group per cycle. Strobes never assert in IDLE or DONE.
// TESTING
// - After reset, PROTECT, violation=0 -> update+enable high in cycle 1 only; cmd_done at
//   cycle 3, result=0x0001; second PROTECT returns 0x0002.
// - PROTECT with violation=1 in CHECK -> update+cancel at cycle 3; cmd_done at cycle 4, fail=1,
//   result=0; next PROTECT ok returns the same id as before.
// - UNPROTECT with spm_current_id=0x0003 -> update+disable pulse, result=1; with id=0 -> fail=1,
//   no strobe.
// - VERIFY_WAIT=3, violation=1 from strobe+2 -> cmd_done at cycle 5, fail=1; violation=0 -> fail=0.
// - handling_irq=1 with cmd_valid=1 -> cmd_ready=0, no acceptance; drop irq -> accepted next cycle.
//   GET_PREV_ID returns spm_prev_id=0x0007.
// - puc_rst in CHECK of PROTECT -> no cancel, no cmd_done, id_shadow=1, cmd_ready=1 next cycle.
//   Op 7 -> fail=1 at cycle 2.

Source files
------------

// File: rtl/omsp_spm_cmd_seq.sv
// rtl/omsp_spm_cmd_seq.sv - Sancus protection command sequencer for omsp_spm_control
//
// Takes one decoded protection command at a time and drives the one-cycle
// update/enable/disable/cancel/verify strobes into omsp_spm_control. It samples
// the violation flag and returns a pass/fail flag and a 16-bit result. A PROTECT
// that raises violation is rolled back with a cancel strobe.
//
// Ports:
//   mclk            core clock
//   puc_rst         synchronous active-high reset
//   cmd_valid       command request, held until accepted
//   cmd_ready       a command can be accepted this cycle
//   cmd_op          1=PROTECT 2=UNPROTECT 3=VERIFY 4=GET_ID 5=GET_PREV_ID, others illegal
//   handling_irq    IRQ entry in progress, blocks acceptance
//   violation       violation flag from omsp_spm_control
//   spm_current_id  current SM id from omsp_spm_control
//   spm_prev_id     previous SM id from omsp_spm_control
//   update_spm, enable_spm, disable_spm, cancel_spm, verify_spm
//                   one-cycle strobes to omsp_spm_control
//   cmd_done        one-cycle completion pulse
//   cmd_fail        valid with cmd_done, 1 = command failed
//   cmd_result      valid with cmd_done, held until the next cmd_done
module omsp_spm_cmd_seq #(
  parameter int VERIFY_WAIT = 1
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        handling_irq,
  input  logic        violation,
  input  logic [15:0] spm_current_id,
  input  logic [15:0] spm_prev_id,
  output logic        update_spm,
  output logic        enable_spm,
  output logic        disable_spm,
  output logic        cancel_spm,
  output logic        verify_spm,
  output logic        cmd_done,
  output logic        cmd_fail,
  output logic [15:0] cmd_result
);

  localparam logic [2:0] OP_PROTECT   = 3'd1;
  localparam logic [2:0] OP_UNPROTECT = 3'd2;
  localparam logic [2:0] OP_VERIFY    = 3'd3;
  localparam logic [2:0] OP_GET_ID    = 3'd4;
  localparam logic [2:0] OP_GET_PREV  = 3'd5;

  // The counter only ever holds VERIFY_WAIT-1 down to 0.
  localparam int CW = (VERIFY_WAIT > 1) ? $clog2(VERIFY_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CHECK,
    S_VWAIT,
    S_CANCEL,
    S_DONE
  } state_t;

  state_t          state;
  logic [2:0]      op;
  logic            unprot_ok;
  logic [15:0]     id_shadow;
  logic [CW-1:0]   wait_cnt;

  assign cmd_ready = (state == S_IDLE) && !handling_irq;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state       <= S_IDLE;
      op          <= 3'd0;
      unprot_ok   <= 1'b0;
      id_shadow   <= 16'h0001;
      wait_cnt    <= '0;
      update_spm  <= 1'b0;
      enable_spm  <= 1'b0;
      disable_spm <= 1'b0;
      cancel_spm  <= 1'b0;
      verify_spm  <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_fail    <= 1'b0;
      cmd_result  <= 16'h0000;
    end else begin
      // Strobes and cmd_done are single-cycle pulses unless set below.
      update_spm  <= 1'b0;
      enable_spm  <= 1'b0;
      disable_spm <= 1'b0;
      cancel_spm  <= 1'b0;
      verify_spm  <= 1'b0;
      cmd_done    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op    <= cmd_op;
            state <= S_ISSUE;
            // Strobes are registered here so they are high during ISSUE.
            case (cmd_op)
              OP_PROTECT: begin
                update_spm <= 1'b1;
                enable_spm <= 1'b1;
              end
              OP_UNPROTECT: begin
                // The id check and the strobe decision are taken together so
                // the reported outcome always matches what was issued.
                if (spm_current_id != 16'h0000) begin
                  update_spm  <= 1'b1;
                  disable_spm <= 1'b1;
                  unprot_ok   <= 1'b1;
                end else begin
                  unprot_ok   <= 1'b0;
                end
              end
              OP_VERIFY: verify_spm <= 1'b1;
              default: ;
            endcase
          end
        end

        S_ISSUE: begin
          case (op)
            OP_PROTECT: state <= S_CHECK;
            OP_UNPROTECT: begin
              state      <= S_DONE;
              cmd_done   <= 1'b1;
              cmd_fail   <= !unprot_ok;
              cmd_result <= {15'd0, unprot_ok};
            end
            OP_VERIFY: begin
              state    <= S_VWAIT;
              wait_cnt <= CW'(VERIFY_WAIT - 1);
            end
            OP_GET_ID: begin
              state      <= S_DONE;
              cmd_done   <= 1'b1;
              cmd_fail   <= 1'b0;
              cmd_result <= spm_current_id;
            end
            OP_GET_PREV: begin
              state      <= S_DONE;
              cmd_done   <= 1'b1;
              cmd_fail   <= 1'b0;
              cmd_result <= spm_prev_id;
            end
            default: begin
              state      <= S_DONE;
              cmd_done   <= 1'b1;
              cmd_fail   <= 1'b1;
              cmd_result <= 16'h0000;
            end
          endcase
        end

        S_CHECK: begin
          if (violation) begin
            // Roll back the enable; the control block's decrement on cancel
            // undoes its increment, so id_shadow stays put.
            update_spm <= 1'b1;
            cancel_spm <= 1'b1;
            state      <= S_CANCEL;
          end else begin
            state      <= S_DONE;
            cmd_done   <= 1'b1;
            cmd_fail   <= 1'b0;
            cmd_result <= id_shadow;
            id_shadow  <= id_shadow + 16'd1;
          end
        end

        S_VWAIT: begin
          if (wait_cnt == '0) begin
            state      <= S_DONE;
            cmd_done   <= 1'b1;
            cmd_fail   <= violation;
            cmd_result <= spm_current_id;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        S_CANCEL: begin
          state      <= S_DONE;
          cmd_done   <= 1'b1;
          cmd_fail   <= 1'b1;
          cmd_result <= 16'h0000;
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// tb/tb_omsp_spm_cmd_seq.sv - self-checking bench for omsp_spm_cmd_seq
module tb_omsp_spm_cmd_seq;

  localparam int W = 3;

  localparam logic [4:0] UPD = 5'b10000;
  localparam logic [4:0] EN  = 5'b01000;
  localparam logic [4:0] DIS = 5'b00100;
  localparam logic [4:0] CAN = 5'b00010;
  localparam logic [4:0] VER = 5'b00001;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic        handling_irq;
  logic        violation;
  logic [15:0] spm_current_id;
  logic [15:0] spm_prev_id;
  logic        update_spm, enable_spm, disable_spm, cancel_spm, verify_spm;
  logic        cmd_done;
  logic        cmd_fail;
  logic [15:0] cmd_result;

  logic [4:0]  strobes;
  assign strobes = {update_spm, enable_spm, disable_spm, cancel_spm, verify_spm};

  omsp_spm_cmd_seq #(.VERIFY_WAIT(W)) dut (
    .mclk           (mclk),
    .puc_rst        (puc_rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .handling_irq   (handling_irq),
    .violation      (violation),
    .spm_current_id (spm_current_id),
    .spm_prev_id    (spm_prev_id),
    .update_spm     (update_spm),
    .enable_spm     (enable_spm),
    .disable_spm    (disable_spm),
    .cancel_spm     (cancel_spm),
    .verify_spm     (verify_spm),
    .cmd_done       (cmd_done),
    .cmd_fail       (cmd_fail),
    .cmd_result     (cmd_result)
  );

  always #5 mclk = ~mclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the id the control block will hand out on the next good PROTECT.
  logic [15:0] m_next_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Violation seen by the DUT in cycle k after acceptance.
  function automatic logic viol_at(input int k, input logic vbit, input int vfrom);
    return (k >= vfrom) ? vbit : 1'b0;
  endfunction

  // Issues one command and checks every cycle up to and just after cmd_done.
  task automatic do_cmd(input logic [2:0] op, input logic vbit, input int vfrom,
                        input int irq_cycles, input logic irq_during);
    logic [4:0]  exp_strb [0:15];
    int          done_k;
    logic        exp_fail;
    logic [15:0] exp_res;
    logic        res_known;

    for (int i = 0; i < 16; i++) exp_strb[i] = 5'b0;
    res_known = 1'b1;
    exp_fail  = 1'b0;
    exp_res   = 16'h0;
    done_k    = 2;

    case (op)
      3'd1: begin
        exp_strb[1] = UPD | EN;
        if (viol_at(2, vbit, vfrom)) begin
          exp_strb[3] = UPD | CAN;
          done_k = 4; exp_fail = 1'b1; exp_res = 16'h0;
        end else begin
          done_k = 3; exp_res = m_next_id;
          m_next_id = m_next_id + 16'd1;
        end
      end
      3'd2: begin
        if (spm_current_id == 16'h0) begin
          exp_fail = 1'b1; res_known = 1'b0;
        end else begin
          exp_strb[1] = UPD | DIS;
          exp_res = 16'h0001;
        end
      end
      3'd3: begin
        exp_strb[1] = VER;
        done_k   = 2 + W;
        exp_fail = viol_at(1 + W, vbit, vfrom);
        exp_res  = spm_current_id;
      end
      3'd4: exp_res = spm_current_id;
      3'd5: exp_res = spm_prev_id;
      default: begin exp_fail = 1'b1; exp_res = 16'h0; end
    endcase

    @(negedge mclk);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    violation    = 1'b0;
    handling_irq = (irq_cycles > 0);
    for (int i = 0; i < irq_cycles; i++) begin
      #1;
      check("irq_blocks_ready", 32'(cmd_ready), 32'd0);
      @(negedge mclk);
      check("irq_no_strobe", 32'(strobes), 32'd0);
      check("irq_no_done", 32'(cmd_done), 32'd0);
      handling_irq = (i + 1 < irq_cycles);
    end
    #1;
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge mclk);

    for (int k = 1; k <= done_k; k++) begin
      @(negedge mclk);
      cmd_valid    = 1'b0;
      handling_irq = irq_during;
      violation    = viol_at(k, vbit, vfrom);
      check($sformatf("strobes_op%0d_c%0d", op, k), 32'(strobes), 32'(exp_strb[k]));
      check($sformatf("done_op%0d_c%0d", op, k), 32'(cmd_done), 32'(k == done_k));
      check("ready_busy", 32'(cmd_ready), 32'd0);
      if (k == done_k) begin
        check($sformatf("fail_op%0d", op), 32'(cmd_fail), 32'(exp_fail));
        if (res_known)
          check($sformatf("result_op%0d", op), 32'(cmd_result), 32'(exp_res));
      end
    end

    @(negedge mclk);
    handling_irq = 1'b0;
    violation    = 1'b0;
    #1;
    check("idle_strobes", 32'(strobes), 32'd0);
    check("idle_done", 32'(cmd_done), 32'd0);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    if (res_known) check("result_held", 32'(cmd_result), 32'(exp_res));
  endtask

  // Reset lands in the CHECK cycle of a PROTECT that would have been cancelled.
  task automatic reset_in_check();
    @(negedge mclk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge mclk);
    @(negedge mclk);
    cmd_valid = 1'b0;
    check("rst_issue_strobe", 32'(strobes), 32'(UPD | EN));
    @(negedge mclk);
    violation = 1'b1;
    puc_rst   = 1'b1;
    @(negedge mclk);
    puc_rst   = 1'b0;
    violation = 1'b0;
    #1;
    check("rst_no_cancel", 32'(strobes), 32'd0);
    check("rst_no_done", 32'(cmd_done), 32'd0);
    check("rst_ready_after", 32'(cmd_ready), 32'd1);
    check("rst_result", 32'(cmd_result), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge mclk);
      check("rst_quiet_strobe", 32'(strobes), 32'd0);
      check("rst_quiet_done", 32'(cmd_done), 32'd0);
    end
    m_next_id = 16'h0001;
  endtask

  initial begin
    puc_rst        = 1'b1;
    cmd_valid      = 1'b0;
    cmd_op         = 3'd0;
    handling_irq   = 1'b0;
    violation      = 1'b0;
    spm_current_id = 16'h0;
    spm_prev_id    = 16'h0;
    m_next_id      = 16'h0001;

    repeat (3) @(posedge mclk);
    @(negedge mclk);
    puc_rst = 1'b0;
    #1;
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_strobes", 32'(strobes), 32'd0);
    check("reset_done", 32'(cmd_done), 32'd0);
    check("reset_fail", 32'(cmd_fail), 32'd0);
    check("reset_result", 32'(cmd_result), 32'd0);

    // PROTECT ok twice, then a cancelled one, then ok again with the same id.
    do_cmd(3'd1, 1'b0, 1, 0, 1'b0);
    do_cmd(3'd1, 1'b0, 1, 0, 1'b0);
    do_cmd(3'd1, 1'b1, 1, 0, 1'b0);
    do_cmd(3'd1, 1'b0, 1, 0, 1'b0);

    spm_current_id = 16'h0003;
    do_cmd(3'd2, 1'b0, 1, 0, 1'b0);
    spm_current_id = 16'h0000;
    do_cmd(3'd2, 1'b0, 1, 0, 1'b0);

    spm_current_id = 16'h0005;
    do_cmd(3'd3, 1'b1, 3, 0, 1'b0);
    do_cmd(3'd3, 1'b0, 3, 0, 1'b0);

    spm_prev_id = 16'h0007;
    do_cmd(3'd5, 1'b0, 1, 3, 1'b0);
    do_cmd(3'd4, 1'b0, 1, 0, 1'b1);

    reset_in_check();
    do_cmd(3'd1, 1'b0, 1, 0, 1'b0);
    do_cmd(3'd7, 1'b0, 1, 0, 1'b0);
    do_cmd(3'd0, 1'b0, 1, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0] rop;
      rop            = 3'($urandom_range(0, 7));
      spm_current_id = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      spm_prev_id    = 16'($urandom);
      do_cmd(rop, 1'($urandom_range(0, 1)), $urandom_range(1, 6),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge mclk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
